// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight writer scoreboard, stall generation, stall statistics; HAZARD_FORWARDING_EN adds forwarding selects
module hazard_scoreboard #(
   parameter int REGISTERNUMBER = 32,
   parameter int DEPTH = 3,
   parameter int RF_BYPASS = 1,
   parameter int FLUSH_DEPTH = 1,
   parameter int CNT_W = 32,
   localparam int RW = $clog2(REGISTERNUMBER),
   localparam int SW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [RW-1:0]    id_rs,
   input  logic [RW-1:0]    id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [RW-1:0]    id_rd,
   input  logic             id_reg_write,
   input  logic             id_is_load,
   input  logic             flush,
   input  logic             cnt_clr,
   output logic             stall,
   output logic [SW-1:0]    fwd_rs_sel,
   output logic [SW-1:0]    fwd_rt_sel,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] hazard_count
);
   localparam int NM = RF_BYPASS != 0 ? DEPTH - 1 : DEPTH;
   logic [DEPTH-1:0] v, wr, ld, rs_m, rt_m;
   logic [RW-1:0]    rd [DEPTH];
   logic             stall_q;
   always_comb begin
      rs_m = '0;
      rt_m = '0;
      for (int i = 0; i < NM; i++) begin
         rs_m[i] = id_use_rs && id_rs != '0 && v[i] && wr[i] && rd[i] != '0 && rd[i] == id_rs;
         rt_m[i] = id_use_rt && id_rt != '0 && v[i] && wr[i] && rd[i] != '0 && rd[i] == id_rt;
      end
   end
`ifdef HAZARD_FORWARDING_EN
   // only a load still in EX cannot be forwarded in time
   assign stall = id_valid && !flush && (rs_m[0] || rt_m[0]) && ld[0];
   always_comb begin
      fwd_rs_sel = '0;
      fwd_rt_sel = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         fwd_rs_sel = rs_m[i] ? SW'(i + 1) : fwd_rs_sel;
         fwd_rt_sel = rt_m[i] ? SW'(i + 1) : fwd_rt_sel;
      end
   end
`else
   assign stall = id_valid && !flush && (|rs_m || |rt_m);
   assign fwd_rs_sel = '0;
   assign fwd_rt_sel = '0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v  <= '0;
         wr <= '0;
         ld <= '0;
         for (int i = 0; i < DEPTH; i++) rd[i] <= '0;
      end else begin
         v[0]  <= id_valid && !stall && !flush;
         rd[0] <= id_rd;
         wr[0] <= id_reg_write;
         ld[0] <= id_is_load;
         for (int i = 1; i < DEPTH; i++) begin
            v[i]  <= v[i-1] && !(flush && i <= FLUSH_DEPTH);
            rd[i] <= rd[i-1];
            wr[i] <= wr[i-1];
            ld[i] <= ld[i-1];
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q      <= 1'b0;
         stall_count  <= '0;
         hazard_count <= '0;
      end else begin
         stall_q      <= stall;
         stall_count  <= cnt_clr ? '0 : (stall && stall_count != '1) ? stall_count + CNT_W'(1) : stall_count;
         hazard_count <= cnt_clr ? '0 : (stall && !stall_q && hazard_count != '1) ? hazard_count + CNT_W'(1) : hazard_count;
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of stall timing, flush, counters and, with HAZARD_FORWARDING_EN, forwarding selects
module tb_hazard_scoreboard;
`ifdef HAZARD_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   logic       clk = 0, rst_n = 0, id_valid = 0, id_use_rs = 0, id_use_rt = 0;
   logic       id_reg_write = 0, id_is_load = 0, flush = 0, cnt_clr = 0, stall;
   logic [4:0] id_rs = 0, id_rt = 0, id_rd = 0;
   logic [1:0] fwd_rs_sel, fwd_rt_sel;
   logic [3:0] stall_count, hazard_count;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   hazard_scoreboard #(.CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
      .id_is_load(id_is_load), .flush(flush), .cnt_clr(cnt_clr), .stall(stall),
      .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .stall_count(stall_count),
      .hazard_count(hazard_count)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #2;
   endtask
   task automatic set_in(input logic [4:0] rs, rt, rd, input logic urs, urt, w, l);
      id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
      id_use_rs = urs; id_use_rt = urt; id_reg_write = w; id_is_load = l;
   endtask
   // hold the instruction in decode until it is accepted, counting stall cycles
   task automatic dispatch(input string tag, input logic [4:0] rs, rt, rd,
                           input logic urs, urt, w, l, input int exp);
      int n = 0;
      set_in(rs, rt, rd, urs, urt, w, l);
      #1;
      while (stall === 1'b1 && n < 20) begin
         n++;
         tick;
      end
      chk(tag, n, exp);
      tick;
      id_valid = 0;
   endtask
   initial begin
      set_in(5, 0, 0, 1, 0, 0, 0);
      #12;
      chk("reset_stall", stall, 0);
      chk("reset_rs_sel", fwd_rs_sel, 0);
      chk("reset_rt_sel", fwd_rt_sel, 0);
      chk("reset_stall_count", stall_count, 0);
      chk("reset_hazard_count", hazard_count, 0);
      rst_n = 1;
      tick;
      chk("empty_stall", stall, 0);
      id_valid = 0;
      dispatch("d1_writer", 0, 0, 3, 0, 0, 1, 0, 0);
      dispatch("d1_reader", 3, 0, 0, 1, 0, 0, 0, FWD ? 0 : 2);
      chk("d1_stall_count", stall_count, FWD ? 0 : 2);
      chk("d1_hazard_count", hazard_count, FWD ? 0 : 1);
      dispatch("d2_writer", 0, 0, 3, 0, 0, 1, 0, 0);
      dispatch("d2_indep", 1, 0, 9, 1, 0, 1, 0, 0);
      dispatch("d2_reader_rt", 0, 3, 0, 0, 1, 0, 0, FWD ? 0 : 1);
      dispatch("r0_writer", 0, 0, 0, 0, 0, 1, 0, 0);
      dispatch("r0_reader", 0, 0, 0, 1, 1, 0, 0, 0);
      dispatch("flush_writer", 0, 0, 7, 0, 0, 1, 0, 0);
      set_in(7, 0, 0, 1, 0, 0, 0);
      flush = 1;
      #1;
      chk("flush_stall", stall, 0);
      tick;
      flush = 0;
      #1;
      chk("post_flush_stall", stall, 0);
      chk("post_flush_rs_sel", fwd_rs_sel, 0);
      chk("post_flush_stall_count", stall_count, FWD ? 0 : 3);
      chk("post_flush_hazard_count", hazard_count, FWD ? 0 : 2);
      dispatch("post_flush_reader", 7, 0, 0, 1, 0, 0, 0, 0);
      for (int k = 0; k < 16; k++) begin
         dispatch("sat_writer", 0, 0, 3, 0, 0, 1, 1, 0);
         dispatch("sat_reader", 3, 0, 0, 1, 0, 0, 0, FWD ? 1 : 2);
      end
      chk("sat_stall_count", stall_count, 15);
      chk("sat_hazard_count", hazard_count, 15);
      dispatch("clr_writer", 0, 0, 3, 0, 0, 1, 1, 0);
      set_in(3, 0, 0, 1, 0, 0, 0);
      cnt_clr = 1;
      #1;
      chk("clr_stall", stall, 1);
      tick;
      cnt_clr = 0;
      #1;
      chk("clr_stall_count", stall_count, 0);
      chk("clr_hazard_count", hazard_count, 0);
      dispatch("clr_reader", 3, 0, 0, 1, 0, 0, 0, FWD ? 0 : 1);
      chk("after_clr_stall_count", stall_count, FWD ? 0 : 1);
      chk("after_clr_hazard_count", hazard_count, 0);
`ifdef HAZARD_FORWARDING_EN
      dispatch("lu_load", 0, 0, 4, 0, 0, 1, 1, 0);
      set_in(4, 0, 0, 1, 0, 0, 0);
      #1;
      chk("lu_stall", stall, 1);
      chk("lu_sel_stalled", fwd_rs_sel, 1);
      tick;
      chk("lu_release", stall, 0);
      chk("lu_sel", fwd_rs_sel, 2);
      tick;
      dispatch("alu_writer", 0, 0, 4, 0, 0, 1, 0, 0);
      set_in(4, 0, 0, 1, 0, 0, 0);
      #1;
      chk("alu_stall", stall, 0);
      chk("alu_sel", fwd_rs_sel, 1);
      tick;
      dispatch("two_w_a", 0, 0, 4, 0, 0, 1, 0, 0);
      dispatch("two_w_b", 0, 0, 4, 0, 0, 1, 0, 0);
      set_in(4, 0, 0, 1, 0, 0, 0);
      #1;
      chk("youngest_sel", fwd_rs_sel, 1);
      tick;
      dispatch("mix_r5", 0, 0, 5, 0, 0, 1, 0, 0);
      dispatch("mix_r4", 0, 0, 4, 0, 0, 1, 0, 0);
      set_in(4, 5, 0, 1, 1, 0, 0);
      #1;
      chk("mix_rs_sel", fwd_rs_sel, 1);
      chk("mix_rt_sel", fwd_rt_sel, 2);
      chk("mix_stall", stall, 0);
      tick;
`else
      dispatch("nf_writer", 0, 0, 4, 0, 0, 1, 0, 0);
      set_in(4, 4, 0, 1, 1, 0, 0);
      #1;
      chk("nf_stall", stall, 1);
      chk("nf_rs_sel", fwd_rs_sel, 0);
      chk("nf_rt_sel", fwd_rt_sel, 0);
      dispatch("nf_reader", 4, 4, 0, 1, 1, 0, 0, 2);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised data-hazard detection unit for the MIPS-lite in-order pipeline. Replaces the per-stage rd/rs buffer comparison with a shift scoreboard of in-flight destination registers.
- Sits beside decode. Compares the decode-stage source registers against every older in-flight writer, drives the pipeline stall, and maintains the stall and data-hazard statistics counters.
- Generalises pipeline depth, register count, register-file bypass and flush depth. Optionally provides forwarding selects.

Parameters:
- REGISTERNUMBER, 32, architectural registers; index width RW = $clog2(REGISTERNUMBER).
- DEPTH, 3, in-flight slots from execute to writeback (slot 0 = EX, slot DEPTH-1 = WB); legal range 2..8.
- RF_BYPASS, 1, 1 = the register file writes before it reads, so slot DEPTH-1 never causes a hazard.
- FLUSH_DEPTH, 1, number of youngest slots (0..FLUSH_DEPTH-1) killed on flush; legal range 0..DEPTH.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode holds a valid instruction.
- id_rs  in  RW  source register 1.
- id_rt  in  RW  source register 2.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_rd  in  RW  destination register.
- id_reg_write  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- flush  in  1  taken branch or jump; squash the younger instructions.
- cnt_clr  in  1  synchronous clear of both counters.
- stall  out  1  hold fetch and decode; a bubble enters EX.
- fwd_rs_sel  out  $clog2(DEPTH+1)  0 = register file; k = forward from slot k-1.
- fwd_rt_sel  out  $clog2(DEPTH+1)  same encoding for rt.
- stall_count  out  CNT_W  total stall cycles.
- hazard_count  out  CNT_W  number of distinct stall episodes (data hazards).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All slots invalid.
  - stall_count=0, hazard_count=0, internal stall_q=0.
  - stall, fwd_rs_sel and fwd_rt_sel are combinational and therefore read 0, because the slots are empty.
- Slot contents: {valid, rd, wr, ld}. A slot is a writer when valid && wr && rd!=0.
- Every clock edge the slots shift: slot i moves to slot i+1, and slot DEPTH-1 retires.
- Slot 0 load rule:
  - If id_valid && !stall && !flush, slot 0 loads {1, id_rd, id_reg_write, id_is_load}.
  - Otherwise slot 0 loads a bubble (valid=0).
- Flush:
  - The same edge clears valid in the post-shift slots 1..FLUSH_DEPTH, i.e. the slots that were 0..FLUSH_DEPTH-1 before the edge.
  - The decode instruction is never entered.
  - flush has priority over stall. stall is forced to 0 while flush=1.
- Operand match: an operand matches slot i when its use bit is 1, the register is nonzero, and slot i is a writer with slot rd == operand.
  - With RF_BYPASS=1, slot DEPTH-1 is excluded from matching.
- stall (no forwarding build) = id_valid && !flush && (rs matches any slot || rt matches any slot). The output is purely combinational, with zero latency.
- Register 0 never matches, including as a destination.
- Counters:
  - stall_count increments on every cycle with stall=1.
  - hazard_count increments when stall && !stall_q, where stall_q is stall registered one cycle.
  - Both counters saturate at 2^CNT_W-1 and do not wrap.
  - cnt_clr=1 zeroes both counters and has priority over an increment in the same cycle.
- Back-to-back dependence behaviour (no forwarding, DEPTH=3, RF_BYPASS=1):
  - Distance 1 gives 2 stall cycles.
  - Distance 2 gives 1 stall cycle.
  - Distance 3 gives 0 stall cycles.
- A stalled instruction is re-evaluated every cycle. The stall releases in the cycle the producer leaves the last matching slot.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined (forwarding build):
  - stall = id_valid && !flush && an operand matches slot 0 with ld=1. This is a load-use hazard only.
  - For each operand, fwd_*_sel = i+1 for the lowest-index (youngest) matching slot i, otherwise 0.
  - While stall=1, the selects still reflect the matches.
  - Distance-1 load-use gives 1 stall cycle. ALU producers give 0 stall cycles.
- Undefined: fwd_rs_sel and fwd_rt_sel are tied to 0, and the stall rule is as in Behaviour.
- Both builds keep identical ports.

Test Plan:
- Reset, then id_valid=1, rs=5, use_rs=1, all slots empty -> stall=0, counters 0.
- Without forwarding: `add r3` followed immediately by `sub` reading r3 -> stall high for exactly 2 cycles, then released; stall_count=2, hazard_count=1.
- Independent instructions, then a reader of r3 two instructions after the writer -> 1 stall cycle. A reader of r0 after a writer of r0 -> 0 stall cycles.
- flush=1 while slot 0 holds a writer of r7 and decode reads r7 -> stall=0 that cycle. On the next cycle a reader of r7 sees no hazard; the killed entry is never counted.
- Counters with CNT_W=4 under a sustained stall -> stall_count saturates at 15. Asserting cnt_clr during an increment -> both counters read 0.
- With HAZARD_FORWARDING_EN:
  - A `lw r4` followed by a reader of r4 -> 1 stall cycle, then fwd_rs_sel=2.
  - An `add r4` followed by a reader of r4 -> 0 stall cycles, fwd_rs_sel=1.
  - Two in-flight writers of r4 -> the youngest (lowest slot index) is selected.
